// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: frames a WIDTH-bit word MSB-first over serial_out while capturing serial_in, DIV clocks per bit.
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             serial_in,
  output logic             serial_out,
  output logic             shift_en,
  output logic             frame,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data
);
  localparam int BW = $clog2(WIDTH);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] tx_sr, rx_sr;
  logic [BW-1:0] bit_cnt;
  logic [DW-1:0] div_cnt;
  logic last;
  always_comb begin
    shift_en = state == SHIFT && div_cnt == DW'(DIV - 1);
    last = shift_en && bit_cnt == BW'(WIDTH - 1);
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? SHIFT : IDLE;
      SHIFT:   state_nx = abort ? IDLE : last ? DONE : SHIFT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_sr <= '0;
      rx_sr <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      rx_data <= '0;
    end else if (state == IDLE && start) begin
      tx_sr <= tx_data;
      rx_sr <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (state == SHIFT) begin
      if (shift_en) begin
        tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
        rx_sr <= {rx_sr[WIDTH-2:0], serial_in};
        bit_cnt <= bit_cnt + BW'(1);
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
      // abort on the final boundary wins, so the received word is dropped
      if (last && !abort) rx_data <= {rx_sr[WIDTH-2:0], serial_in};
    end
  end
  assign serial_out = state == SHIFT && tx_sr[WIDTH-1];
  assign frame = state == SHIFT;
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: random and directed frames on a 4x2 and an 8x1 instance against a per-bit-period model.
module tb_shift_seq_ctrl;
  logic clk = 1'b0;
  logic [1:0] rst, st, ab, sin, so, se, fr, bz, dn;
  logic [7:0] txd [2];
  logic [3:0] rx4;
  logic [7:0] rx8;
  logic [7:0] rx_exp [2];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(4), .DIV(2)) u4 (
    .clk(clk), .reset(rst[0]), .start(st[0]), .abort(ab[0]), .tx_data(txd[0][3:0]),
    .serial_in(sin[0]), .serial_out(so[0]), .shift_en(se[0]), .frame(fr[0]),
    .busy(bz[0]), .done(dn[0]), .rx_data(rx4));

  shift_seq_ctrl #(.WIDTH(8), .DIV(1)) u8 (
    .clk(clk), .reset(rst[1]), .start(st[1]), .abort(ab[1]), .tx_data(txd[1]),
    .serial_in(sin[1]), .serial_out(so[1]), .shift_en(se[1]), .frame(fr[1]),
    .busy(bz[1]), .done(dn[1]), .rx_data(rx8));

  function automatic logic [7:0] rxv(int i);
    return i != 0 ? rx8 : {4'b0, rx4};
  endfunction

  task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic idle_chk(int i);
    chk("idle_busy", i, 32'(bz[i]), 0);
    chk("idle_frame", i, 32'(fr[i]), 0);
    chk("idle_done", i, 32'(dn[i]), 0);
    chk("idle_shift_en", i, 32'(se[i]), 0);
    chk("idle_serial_out", i, 32'(so[i]), 0);
    chk("idle_rx_data", i, 32'(rxv(i)), 32'(rx_exp[i]));
  endtask

  // mode: 0 loopback, 1 serial_in tied high, 2 random serial_in
  task automatic run_frame(int i, logic [7:0] tx, int mode, int abort_at, int reset_at, bit hold);
    int w = i != 0 ? 8 : 4;
    int d = i != 0 ? 1 : 2;
    logic [7:0] rxw = '0;
    logic [7:0] mask = 8'((1 << w) - 1);
    logic b;
    @(negedge clk);
    idle_chk(i);
    st[i] = 1'b1;
    txd[i] = tx;
    ab[i] = 1'($urandom);
    for (int k = 1; k <= w * d; k++) begin
      @(negedge clk);
      b = tx[w - 1 - (k - 1) / d];
      chk("frame", i, 32'(fr[i]), 1);
      chk("busy", i, 32'(bz[i]), 1);
      chk("done_early", i, 32'(dn[i]), 0);
      chk("shift_en", i, 32'(se[i]), 32'(k % d == 0));
      chk("serial_out", i, 32'(so[i]), 32'(b));
      chk("rx_stable", i, 32'(rxv(i)), 32'(rx_exp[i]));
      st[i] = hold;
      txd[i] = 8'($urandom);
      ab[i] = k == abort_at;
      rst[i] = k == reset_at;
      sin[i] = mode == 0 ? so[i] : mode == 1 ? 1'b1 : 1'($urandom);
      if (k % d == 0) rxw = {rxw[6:0], sin[i]};
      if (k == abort_at || k == reset_at) begin
        @(posedge clk);
        #1;
        if (k == reset_at) rx_exp[i] = '0;
        ab[i] = 1'b0;
        rst[i] = 1'b0;
        st[i] = 1'b0;
        return;
      end
    end
    @(negedge clk);
    chk("done", i, 32'(dn[i]), 1);
    chk("done_busy", i, 32'(bz[i]), 1);
    chk("done_frame", i, 32'(fr[i]), 0);
    chk("done_serial_out", i, 32'(so[i]), 0);
    chk("done_rx_data", i, 32'(rxv(i)), 32'(rxw & mask));
    rx_exp[i] = rxw & mask;
    st[i] = hold;
    ab[i] = 1'($urandom);
  endtask

  initial begin
    rst = 2'b11;
    st = 2'b11;
    ab = 2'b11;
    sin = 2'b11;
    txd[0] = 8'hFF;
    txd[1] = 8'hFF;
    rx_exp[0] = '0;
    rx_exp[1] = '0;
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      idle_chk(0);
      idle_chk(1);
    end
    rst = 2'b00;
    st = 2'b00;
    ab = 2'b00;
    run_frame(0, 8'h0B, 0, 0, 0, 1'b0);
    run_frame(0, 8'h06, 1, 0, 0, 1'b1);
    run_frame(0, 8'h06, 1, 0, 0, 1'b0);
    run_frame(0, 8'h09, 2, 5, 0, 1'b0);
    run_frame(0, 8'h0D, 0, 0, 0, 1'b0);
    run_frame(0, 8'h07, 2, 4, 0, 1'b0);
    run_frame(0, 8'h0E, 2, 8, 0, 1'b0);
    run_frame(0, 8'h05, 2, 0, 4, 1'b0);
    run_frame(0, 8'h0C, 0, 0, 0, 1'b0);
    run_frame(1, 8'hA5, 0, 0, 0, 1'b0);
    run_frame(1, 8'h3C, 2, 8, 0, 1'b0);
    run_frame(1, 8'h5A, 2, 0, 3, 1'b0);
    for (int r = 0; r < 16; r++)
      run_frame(r % 2, 8'($urandom), int'($urandom_range(0, 2)),
                $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 8)) : 0, 0, 1'($urandom));
    st = 2'b00;
    @(negedge clk);
    @(negedge clk);
    idle_chk(0);
    idle_chk(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
